hook_release_ctrl: RTL
======================

Name: hook_release_ctrl

Overview:
- Initiator side of the hook release/retract timing handshake in the gold-miner game datapath.
- Drives `counter_en` into the release-and-back frame counter and consumes its single-cycle `step_tick` to advance the hook length outward, then back.
- Reports grab results to the scoring and sprite logic.
- Sits between the keyboard/fire decoder, the collision detector and the hook renderer.

Parameters:
- LEN_W, 8, width of `hook_len`.
- MAX_LEN, 160, maximum extension in pixels; must be ≤ 2^LEN_W-1 and a multiple of STEP.
- STEP, 2, pixels moved per accepted `step_tick`.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- resetn  in  1  asynchronous active-low reset.
- fire  in  1  level; sampled only in IDLE; launches the hook.
- hit  in  1  level from the collision detector; sampled only in EXTEND.
- step_tick  in  1  single-cycle pulse from the frame counter.
- counter_en  out  1  enable to the frame counter; its low level clears that counter.
- hook_len  out  LEN_W  current extension, 0..MAX_LEN.
- busy  out  1  high in any state other than IDLE.
- grabbed  out  1  high from the hit until the return to IDLE.
- done  out  1  one-cycle pulse when the hook is home again.

Behaviour:
- Reset values (asynchronous, effective immediately, including mid-operation): state=IDLE, hook_len=0, counter_en=0, busy=0, grabbed=0, done=0, weight sub-counter=0.
- All outputs are registered.
- States: IDLE, EXTEND, TURN, RETRACT, DONE.
- IDLE:
  - `fire`=1 → EXTEND next cycle; `counter_en`=1 from that cycle.
  - `step_tick` and `hit` are ignored.
- EXTEND:
  - `hit`=1 → TURN and `grabbed`<=1, with no length change.
  - `hit` takes priority over a simultaneous `step_tick`.
  - Else on `step_tick`: if `hook_len`+STEP ≥ MAX_LEN, then `hook_len`<=MAX_LEN and go to TURN; otherwise `hook_len`+=STEP.
  - Addition is performed at LEN_W+1 bits, so no wrap occurs.
- TURN:
  - Exactly one cycle with `counter_en`=0, which restarts the frame counter's delay phase.
  - A `step_tick` arriving in TURN is discarded.
  - Always → RETRACT.
- RETRACT (`counter_en`=1):
  - On an accepted tick: if `hook_len` ≤ STEP, then `hook_len`<=0 and go to DONE; otherwise `hook_len`-=STEP.
  - No underflow is permitted.
  - `hit` is ignored.
- DONE:
  - One cycle with `counter_en`=0 and `done`=1; `grabbed` is still valid this cycle.
  - Then → IDLE and `grabbed`<=0.
- `fire` held continuously relaunches the hook on the IDLE cycle after DONE. There is no edge detection.
- `fire` outside IDLE is ignored.
- `busy` is combinationally equivalent to state≠IDLE but is registered alongside the state.
- A `hit` in the same cycle as the final extending step still takes the grab path: the hook goes to TURN with `grabbed`=1 and `hook_len` unchanged.

Optional Feature:
- Macro name: HOOK_WEIGHT_EN.
- Defined:
  - Adds input port `weight` [1:0], the load class of the grabbed object, sampled on the `hit` cycle and latched.
  - In RETRACT with `grabbed`=1, only every (weight+1)-th `step_tick` is accepted; a 2-bit sub-counter counts the others.
  - The sub-counter clears on entry to RETRACT and on each accepted tick.
  - Latched weight=0 behaves as if undefined.
- Undefined:
  - No `weight` port and no sub-counter.
  - Every RETRACT `step_tick` is accepted.

Decomposition:
- Package `hook_pkg`: state encoding constants (IDLE=0, EXTEND=1, TURN=2, RETRACT=3, DONE=4, 3-bit), default LEN_W/MAX_LEN/STEP values, weight class constants.
- Sub-module `hook_tick_divider`:
  - Inputs: clk, resetn, clear, tick, ratio[1:0].
  - Output: accept pulse.
  - Built only under HOOK_WEIGHT_EN; otherwise accept=tick.

Test Plan:
- Full stroke, no hit:
  - Stimulus: pulse `fire`, then `step_tick` every 10 cycles.
  - Required response: `hook_len` reaches 160 after 80 ticks; TURN shows `counter_en`=0 for 1 cycle; 80 more ticks return `hook_len` to 0; `done` pulses once with `grabbed`=0; `busy` drops the following cycle.
- Grab:
  - Stimulus: `hit` at `hook_len`=40, arriving in the same cycle as a `step_tick`.
  - Required response: `hook_len` stays 40; `grabbed`=1; 20 ticks to home; `done`=1 with `grabbed`=1; `grabbed`=0 the next cycle.
- Ignored inputs:
  - Stimulus: `fire` asserted during EXTEND; `hit` asserted during RETRACT; `step_tick` in TURN and in IDLE.
  - Required response: no state or length change from any of them.
- Reset mid-RETRACT:
  - Stimulus: deassert `resetn` at `hook_len`=100, asynchronously between clock edges.
  - Required response: all outputs go to reset values before the next edge; after release the block sits in IDLE until `fire`.
- HOOK_WEIGHT_EN:
  - Stimulus: weight=2, grab at `hook_len`=20.
  - Required response: 30 ticks are needed to reach 0 (every 3rd tick accepted).
  - Also: with weight=0 or no grab, retract takes 1 tick per step.

Source files
------------

// File: rtl/hook_pkg.sv
// Shared constants for the hook release/retract controller.
// State encoding, default geometry and grabbed-object weight classes.
package hook_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXTEND  = 3'd1,
    S_TURN    = 3'd2,
    S_RETRACT = 3'd3,
    S_DONE    = 3'd4
  } hook_state_e;

  localparam int HOOK_LEN_W   = 8;
  localparam int HOOK_MAX_LEN = 160;
  localparam int HOOK_STEP    = 2;

  // Load classes: retract accepts every (class+1)-th frame tick.
  localparam logic [1:0] WGT_LIGHT  = 2'd0;
  localparam logic [1:0] WGT_MEDIUM = 2'd1;
  localparam logic [1:0] WGT_HEAVY  = 2'd2;
  localparam logic [1:0] WGT_MAX    = 2'd3;

endpackage

// File: rtl/hook_tick_divider.sv
// Frame-tick divider for weighted retract: passes every (ratio+1)-th tick.
// Instantiated by hook_release_ctrl only when HOOK_WEIGHT_EN is defined.
module hook_tick_divider (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       tick,
  input  logic [1:0] ratio,
  output logic       accept
);

  logic [1:0] cnt;

  // A tick is accepted once the skipped-tick count has caught up with ratio.
  assign accept = tick && !clear && (cnt == ratio);

  // Count skipped ticks; restart on clear and on every accepted tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       cnt <= 2'd0;
    else if (clear)    cnt <= 2'd0;
    else if (accept)   cnt <= 2'd0;
    else if (tick)     cnt <= cnt + 2'd1;
  end

endmodule

// File: rtl/hook_release_ctrl.sv
// Hook release/retract controller: drives the frame counter enable, steps
// hook_len out and back on step_tick, and reports grabs and completion.
// Optional HOOK_WEIGHT_EN: adds a weight input that slows a loaded retract.
module hook_release_ctrl
  import hook_pkg::*;
#(
  parameter int LEN_W   = HOOK_LEN_W,
  parameter int MAX_LEN = HOOK_MAX_LEN,
  parameter int STEP    = HOOK_STEP
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             fire,
  input  logic             hit,
  input  logic             step_tick,
`ifdef HOOK_WEIGHT_EN
  input  logic [1:0]       weight,
`endif
  output logic             counter_en,
  output logic [LEN_W-1:0] hook_len,
  output logic             busy,
  output logic             grabbed,
  output logic             done
);

  localparam logic [LEN_W:0]   MAX_W  = (LEN_W+1)'(MAX_LEN);
  localparam logic [LEN_W:0]   STEP_W = (LEN_W+1)'(STEP);
  localparam logic [LEN_W-1:0] STEP_L = LEN_W'(STEP);
  localparam logic [LEN_W-1:0] MAX_L  = LEN_W'(MAX_LEN);

  hook_state_e      state, state_nxt;
  logic [LEN_W-1:0] len_nxt;
  logic             grabbed_nxt;
  logic [LEN_W:0]   len_up;
  logic             rtick;
  logic             accept;

  // One bit of headroom so the outward step can never wrap.
  assign len_up = {1'b0, hook_len} + STEP_W;
  assign rtick  = step_tick && (state == S_RETRACT);

`ifdef HOOK_WEIGHT_EN
  logic [1:0] weight_q;

  // Weight class is captured on the grab cycle and held for the retract.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                         weight_q <= WGT_LIGHT;
    else if (state == S_EXTEND && hit)   weight_q <= weight;
  end

  hook_tick_divider u_div (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state == S_TURN),
    .tick   (rtick),
    .ratio  (grabbed ? weight_q : WGT_LIGHT),
    .accept (accept)
  );
`else
  assign accept = rtick;
`endif

  // State and registered outputs; outputs follow the next state so they
  // line up with it cycle-for-cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      hook_len   <= '0;
      counter_en <= 1'b0;
      busy       <= 1'b0;
      grabbed    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      hook_len   <= len_nxt;
      counter_en <= (state_nxt == S_EXTEND) || (state_nxt == S_RETRACT);
      busy       <= (state_nxt != S_IDLE);
      grabbed    <= grabbed_nxt;
      done       <= (state_nxt == S_DONE);
    end
  end

  // Next-state logic; hit beats a coincident step in EXTEND.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (fire) state_nxt = S_EXTEND;
      S_EXTEND:  if (hit || (step_tick && len_up >= MAX_W)) state_nxt = S_TURN;
      S_TURN:    state_nxt = S_RETRACT;
      S_RETRACT: if (accept && hook_len <= STEP_L) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Length and grab flag updates.
  always_comb begin
    len_nxt     = hook_len;
    grabbed_nxt = grabbed;
    case (state)
      S_EXTEND: begin
        if (hit)                    grabbed_nxt = 1'b1;
        else if (step_tick)         len_nxt = (len_up >= MAX_W) ? MAX_L : len_up[LEN_W-1:0];
      end
      S_RETRACT: begin
        if (accept)                 len_nxt = (hook_len <= STEP_L) ? '0 : hook_len - STEP_L;
      end
      S_DONE:                       grabbed_nxt = 1'b0;
      default: ;
    endcase
  end

endmodule
